// File: rtl/player_anim_ctrl_pkg.sv
// Shared definitions for the player animation controller: state encodings,
// sprite ROM bases, animation frame counts and input bit positions.
package player_anim_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WALK  = 3'd1,
    ST_PUNCH = 3'd2,
    ST_KICK  = 3'd3,
    ST_BLOCK = 3'd4,
    ST_JUMP  = 3'd5
  } anim_state_e;

  localparam logic [3:0] SPR_IDLE  = 4'd0;
  localparam logic [3:0] SPR_WALK  = 4'd1;
  localparam logic [3:0] SPR_PUNCH = 4'd5;
  localparam logic [3:0] SPR_KICK  = 4'd8;
  localparam logic [3:0] SPR_BLOCK = 4'd11;
  localparam logic [3:0] SPR_JUMP  = 4'd12;

  localparam int WALK_FRAMES   = 4;
  localparam int ATTACK_FRAMES = 3;

  localparam int IN_LEFT   = 0;
  localparam int IN_RIGHT  = 1;
  localparam int IN_JUMP   = 2;
  localparam int IN_UNUSED = 3;
  localparam int IN_PUNCH  = 4;
  localparam int IN_KICK   = 5;
  localparam int IN_BLOCK  = 6;

  function automatic logic [3:0] sprite_for(input anim_state_e st, input logic [1:0] idx);
    logic [3:0] spr;
    case (st)
      ST_WALK:  spr = SPR_WALK  + {2'b00, idx};
      ST_PUNCH: spr = SPR_PUNCH + {2'b00, idx};
      ST_KICK:  spr = SPR_KICK  + {2'b00, idx};
      ST_BLOCK: spr = SPR_BLOCK;
      ST_JUMP:  spr = SPR_JUMP;
      default:  spr = SPR_IDLE;
    endcase
    return spr;
  endfunction

endpackage

// File: rtl/player_anim_ctrl.sv
// Per-player move FSM and position datapath; every register advances only on
// a frame_tick cycle so the sprite path never sees a mid-frame change.
//
// state | meaning
// IDLE  | standing, accepts any move request
// WALK  | exactly one of left/right held, x steps each tick
// PUNCH | fixed 3-sub-frame attack, inputs ignored
// KICK  | fixed 3-sub-frame attack, inputs ignored
// BLOCK | held while the block input stays set
// JUMP  | ballistic y, x still steerable, lands on the floor
module player_anim_ctrl
  import player_anim_ctrl_pkg::*;
#(
  parameter int FRAME_TICKS = 4,
  parameter int MOVE_STEP   = 2,
  parameter int X_INIT      = 60,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 512,
  parameter int FLOOR_Y     = 266,
  parameter int JUMP_V      = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [6:0] player_inputs,
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic [3:0] sprite_sel,
  output logic       attack_active,
  output logic       blocking,
  output logic [2:0] state
);

  localparam int CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(FRAME_TICKS - 1);
  localparam logic [1:0]       WALK_LAST   = 2'(WALK_FRAMES - 1);
  localparam logic [1:0]       ATTACK_LAST = 2'(ATTACK_FRAMES - 1);

  localparam logic signed [11:0] STEP_S   = 12'(MOVE_STEP);
  localparam logic signed [11:0] XMIN_S   = 12'(X_MIN);
  localparam logic signed [11:0] XMAX_S   = 12'(X_MAX);
  localparam logic [9:0]         XMIN_10  = 10'(X_MIN);
  localparam logic [9:0]         XMAX_10  = 10'(X_MAX);
  localparam logic [9:0]         XINIT_10 = 10'(X_INIT);
  localparam logic [9:0]         FLOOR_10 = 10'(FLOOR_Y);
  localparam logic signed [10:0] FLOOR_S  = 11'(FLOOR_Y);
  localparam logic signed [5:0]  VY_ENTRY = 6'(-JUMP_V);

  anim_state_e            state_q, state_d;
  logic [9:0]             x_q, x_d, y_q, y_d;
  logic signed [5:0]      vy_q, vy_d, vy_use;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             idx_q, idx_d;
  logic [3:0]             sprite_q, sprite_d;
  logic                   attack_q, attack_d;
  logic                   blocking_q, blocking_d;

  logic                   left, right, walk_req;
  logic                   punch_in, kick_in, block_in, jump_in;
  logic                   unused_in;
  logic signed [11:0]     x_s, x_inc, x_dec;
  logic [9:0]             x_moved;
  logic signed [10:0]     y_sum;
  logic                   land;

  assign left      = player_inputs[IN_LEFT];
  assign right     = player_inputs[IN_RIGHT];
  assign jump_in   = player_inputs[IN_JUMP];
  assign punch_in  = player_inputs[IN_PUNCH];
  assign kick_in   = player_inputs[IN_KICK];
  assign block_in  = player_inputs[IN_BLOCK];
  assign unused_in = player_inputs[IN_UNUSED];
  assign walk_req  = left ^ right;

  // Horizontal step with saturation at both screen edges.
  always_comb begin
    x_s     = signed'({2'b00, x_q});
    x_inc   = x_s + STEP_S;
    x_dec   = x_s - STEP_S;
    x_moved = x_q;
    if (right && !left)
      x_moved = (x_inc > XMAX_S) ? XMAX_10 : x_inc[9:0];
    else if (left && !right)
      x_moved = (x_dec < XMIN_S) ? XMIN_10 : x_dec[9:0];
  end

  // The entry tick of a jump already applies the launch velocity.
  always_comb begin
    vy_use = (state_q == ST_JUMP) ? vy_q : VY_ENTRY;
    y_sum  = signed'({1'b0, y_q}) + signed'({{5{vy_use[5]}}, vy_use});
    land   = (vy_use > 6'sd0) && (y_sum >= FLOOR_S);
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vy_d    = vy_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;

    case (state_q)
      ST_IDLE, ST_WALK: begin
        if (punch_in)      state_d = ST_PUNCH;
        else if (kick_in)  state_d = ST_KICK;
        else if (block_in) state_d = ST_BLOCK;
        else if (jump_in)  state_d = ST_JUMP;
        else if (walk_req) state_d = ST_WALK;
        else               state_d = ST_IDLE;

        if (state_d == ST_WALK || state_d == ST_JUMP)
          x_d = x_moved;
        if (state_d == ST_JUMP) begin
          y_d  = y_sum[9:0];
          vy_d = vy_use + 6'sd1;
        end
      end
      ST_PUNCH, ST_KICK: begin
        if (idx_q == ATTACK_LAST && cnt_q == CNT_LAST)
          state_d = ST_IDLE;
      end
      ST_BLOCK: begin
        if (!block_in)
          state_d = ST_IDLE;
      end
      ST_JUMP: begin
        x_d = x_moved;
        if (land) begin
          y_d     = FLOOR_10;
          vy_d    = 6'sd0;
          state_d = ST_IDLE;
        end else begin
          y_d  = y_sum[9:0];
          vy_d = vy_use + 6'sd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (state_q == ST_WALK || state_q == ST_PUNCH || state_q == ST_KICK) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (state_q == ST_WALK && idx_q == WALK_LAST)
          idx_d = '0;
        else
          idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    sprite_d   = sprite_for(state_d, idx_d);
    attack_d   = (state_d == ST_PUNCH || state_d == ST_KICK) && (idx_d == 2'd1);
    blocking_d = (state_d == ST_BLOCK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      x_q        <= XINIT_10;
      y_q        <= FLOOR_10;
      vy_q       <= 6'sd0;
      cnt_q      <= '0;
      idx_q      <= '0;
      sprite_q   <= SPR_IDLE;
      attack_q   <= 1'b0;
      blocking_q <= 1'b0;
    end else if (frame_tick) begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      vy_q       <= vy_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sprite_q   <= sprite_d;
      attack_q   <= attack_d;
      blocking_q <= blocking_d;
    end
  end

  assign player_x      = x_q;
  assign player_y      = y_q;
  assign sprite_sel    = sprite_q;
  assign attack_active = attack_q;
  assign blocking      = blocking_q;
  assign state         = state_q;

endmodule

// File: tb/tb_player_anim_ctrl.sv
// Bench for player_anim_ctrl: directed scenarios plus random input runs, all
// checked against a tick-count based behavioural model.
module tb_player_anim_ctrl;

  localparam int FT    = 4;
  localparam int STEP  = 2;
  localparam int XI    = 60;
  localparam int XMIN  = 0;
  localparam int XMAX  = 512;
  localparam int FLOOR = 266;
  localparam int JV    = 10;

  localparam logic [6:0] I_LEFT  = 7'h01;
  localparam logic [6:0] I_RIGHT = 7'h02;
  localparam logic [6:0] I_JUMP  = 7'h04;
  localparam logic [6:0] I_PUNCH = 7'h10;
  localparam logic [6:0] I_KICK  = 7'h20;
  localparam logic [6:0] I_BLOCK = 7'h40;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic [6:0] player_inputs;
  logic [9:0] player_x, player_y;
  logic [3:0] sprite_sel;
  logic       attack_active, blocking;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  // model: state 0..5 = idle, walk, punch, kick, block, jump; m_t = ticks since entry
  int m_st, m_x, m_y, m_vy, m_t;

  wire [28:0] dut_vec = {player_x, player_y, sprite_sel, attack_active, blocking, state};

  player_anim_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .player_inputs(player_inputs),
    .player_x(player_x), .player_y(player_y), .sprite_sel(sprite_sel),
    .attack_active(attack_active), .blocking(blocking), .state(state)
  );

  always #5 clk = ~clk;

  function automatic int clamp_x(input int v);
    if (v < XMIN) return XMIN;
    if (v > XMAX) return XMAX;
    return v;
  endfunction

  function automatic logic [28:0] exp_vec();
    int spr;
    case (m_st)
      0: spr = 0;
      1: spr = 1 + (m_t / FT) % 4;
      2: spr = 5 + m_t / FT;
      3: spr = 8 + m_t / FT;
      4: spr = 11;
      default: spr = 12;
    endcase
    return {10'(m_x), 10'(m_y), 4'(spr),
            1'((m_st == 2 || m_st == 3) && (m_t / FT) == 1), 1'(m_st == 4), 3'(m_st)};
  endfunction

  task automatic model_reset();
    m_st = 0; m_x = XI; m_y = FLOOR; m_vy = 0; m_t = 0;
  endtask

  task automatic model_tick(input logic [6:0] in);
    bit l, r, j, p, k, b;
    int dx, ns;
    l = in[0]; r = in[1]; j = in[2]; p = in[4]; k = in[5]; b = in[6];
    dx = (l ^ r) ? (r ? STEP : -STEP) : 0;
    case (m_st)
      0, 1: begin
        if (p) ns = 2; else if (k) ns = 3; else if (b) ns = 4;
        else if (j) ns = 5; else if (l ^ r) ns = 1; else ns = 0;
        if (ns == 1 || ns == 5) m_x = clamp_x(m_x + dx);
        if (ns == 5) begin m_y = m_y - JV; m_vy = -JV + 1; end
        m_t = (ns == m_st) ? m_t + 1 : 0;
        m_st = ns;
      end
      2, 3: if (m_t + 1 == 3 * FT) begin m_st = 0; m_t = 0; end else m_t++;
      4: if (!b) begin m_st = 0; m_t = 0; end else m_t++;
      default: begin
        m_x = clamp_x(m_x + dx);
        if (m_vy > 0 && m_y + m_vy >= FLOOR) begin
          m_y = FLOOR; m_vy = 0; m_st = 0; m_t = 0;
        end else begin
          m_y = m_y + m_vy; m_vy++; m_t++;
        end
      end
    endcase
  endtask

  // One frame: inputs valid at the tick edge, then junk inputs that must be ignored.
  task automatic do_tick(input logic [6:0] in);
    @(negedge clk);
    player_inputs = in;
    frame_tick    = 1'b1;
    @(negedge clk);
    frame_tick    = 1'b0;
    player_inputs = 7'($urandom);
    model_tick(in);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_tick = 1'b0; player_inputs = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL reset: got %h expected %h", dut_vec, exp_vec());
    end
    for (int i = 0; i < 3; i++) begin
      do_tick(7'h00);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL idle tick %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if (player_x !== 10'd60 || player_y !== 10'd266 || sprite_sel !== 4'd0 || state !== 3'd0) begin
      n_err++; $display("FAIL idle_final: got x=%0d y=%0d spr=%0d st=%0d expected 60 266 0 0",
                        player_x, player_y, sprite_sel, state);
    end
  endtask

  task automatic test_walk();
    logic [3:0] spr_seq [10] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3};
    for (int i = 0; i < 10; i++) begin
      do_tick(I_RIGHT);
      n_cmp++;
      if (dut_vec !== exp_vec() || sprite_sel !== spr_seq[i]) begin
        n_err++; $display("FAIL walk_right tick %0d: got %h spr %0d expected %h spr %0d",
                          i, dut_vec, sprite_sel, exp_vec(), spr_seq[i]);
      end
    end
    n_cmp++;
    if (player_x !== 10'd80) begin
      n_err++; $display("FAIL walk_x80: got %0d expected 80", player_x);
    end
    for (int i = 0; i < 215; i++) begin
      do_tick(I_RIGHT);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL walk_long tick %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if (player_x !== 10'd510) begin
      n_err++; $display("FAIL walk_x510: got %0d expected 510", player_x);
    end
    for (int i = 0; i < 3; i++) do_tick(I_RIGHT);
    n_cmp++;
    if (player_x !== 10'd512 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL walk_sat_max: got x=%0d vec %h expected 512 vec %h", player_x, dut_vec, exp_vec());
    end
    for (int i = 0; i < 260; i++) do_tick(I_LEFT);
    n_cmp++;
    if (player_x !== 10'd0 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL walk_sat_min: got x=%0d vec %h expected 0 vec %h", player_x, dut_vec, exp_vec());
    end
    do_tick(I_LEFT | I_RIGHT);
    n_cmp++;
    if (state !== 3'd0 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL walk_both_dirs: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_punch();
    int att_ticks = 0;
    do_tick(I_PUNCH);
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (dut_vec !== exp_vec() || state !== 3'd2) begin
        n_err++; $display("FAIL punch tick %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
      if (attack_active) att_ticks++;
      do_tick((i >= 4 && i < 7) ? I_KICK : 7'h00);
    end
    n_cmp++;
    if (att_ticks != 4 || state !== 3'd0 || sprite_sel !== 4'd0) begin
      n_err++; $display("FAIL punch_end: got att=%0d st=%0d spr=%0d expected 4 0 0",
                        att_ticks, state, sprite_sel);
    end
  endtask

  task automatic test_jump(input logic [6:0] held, input bit check_peak);
    int ys[$];
    int min_y = 1023;
    do_tick(I_JUMP | held);
    for (int i = 0; i < 40 && state === 3'd5; i++) begin
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL jump tick %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
      ys.push_back(int'(player_y));
      if (int'(player_y) < min_y) min_y = int'(player_y);
      do_tick(I_PUNCH | I_JUMP | held);
    end
    n_cmp++;
    if (state !== 3'd0 || player_y !== 10'd266 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL jump_land: got %h expected %h", dut_vec, exp_vec());
    end
    if (check_peak) begin
      n_cmp++;
      if (ys.size() < 3 || ys[0] != 256 || ys[1] != 247 || ys[2] != 239 || min_y != 211) begin
        n_err++; $display("FAIL jump_profile: got n=%0d peak=%0d expected 256,247,239 peak 211",
                          ys.size(), min_y);
      end
    end
  endtask

  task automatic test_block();
    int held = 0;
    for (int i = 0; i < 5; i++) begin
      do_tick(I_BLOCK);
      if (blocking === 1'b1 && sprite_sel === 4'd11) held++;
    end
    do_tick(7'h00);
    n_cmp++;
    if (held != 5 || state !== 3'd0 || blocking !== 1'b0 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL block_release: got held=%0d vec %h expected 5 vec %h", held, dut_vec, exp_vec());
    end
    do_tick(I_PUNCH | I_BLOCK);
    n_cmp++;
    if (state !== 3'd2 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL punch_over_block: got %h expected %h", dut_vec, exp_vec());
    end
    for (int i = 0; i < 12; i++) do_tick(7'h00);
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL punch_over_block_end: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_reset_mid(input logic [6:0] start, input int n);
    do_tick(start);
    for (int i = 0; i < n; i++) do_tick(7'h00);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL reset_async: got %h expected %h", dut_vec, exp_vec());
    end
    @(negedge clk);
    player_inputs = I_RIGHT;
    frame_tick    = 1'b1;
    @(negedge clk);
    frame_tick    = 1'b0;
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL tick_in_reset: got %h expected %h", dut_vec, exp_vec());
    end
    rst = 1'b0;
    do_tick(I_RIGHT);
    n_cmp++;
    if (state !== 3'd1 || player_x !== 10'd62 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL after_reset: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    logic [6:0] mask, in;
    for (int seg = 0; seg < 25; seg++) begin
      case ($urandom_range(0, 3))
        0: mask = 7'h7F;
        1: mask = 7'h03;
        2: mask = 7'h07;
        default: mask = 7'h47;
      endcase
      for (int i = 0; i < 20; i++) begin
        in = 7'($urandom) & mask;
        do_tick(in);
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
          n_err++; $display("FAIL random seg %0d tick %0d in %h: got %h expected %h",
                            seg, i, in, dut_vec, exp_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_walk();
    test_punch();
    test_jump(7'h00, 1'b1);
    test_jump(I_RIGHT, 1'b0);
    test_block();
    test_reset_mid(I_KICK, 5);
    test_reset_mid(I_JUMP, 4);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
